jesd204b_rx_link_ctrl: RTL
==========================

Name: jesd204b_rx_link_ctrl

Overview:
- Single-lane JESD204B receive link controller: code-group sync (CGS), initial lane alignment sequence (ILAS) check, then user-data phase.
- Sits between the 8b/10b decoder (32-bit word, 4 K-flags) and the lane descrambler.
- Drives SYNC~, the descrambler reset and the data-valid strobes.
- Returns to CGS on link errors or on an application request.

Parameters:
- F, 2: octets per frame (1, 2 or 4).
- K, 32: frames per multiframe; F*K is a multiple of 4; MF_WORDS = F*K/4.
- ILAS_MF, 4: ILAS length in multiframes.
- CGS_WORDS, 4: consecutive all-/K/ words required for CGS lock.
- ILAS_TMO, 1024: clk cycles allowed in ILAS_WAIT before fallback to CGS.
- ERR_THR, 8: DATA-phase error words before relink.

Ports:
- clk  in  1  word clock.
- reset  in  1  synchronous, active-high.
- d_in  in  32  decoded octets; byte 0 = d_in[7:0] is earliest.
- k_in  in  4  K-flag per byte.
- dec_err  in  4  per-byte disparity / not-in-table error from decoder.
- relink  in  1  one-cycle pulse: force return to CGS.
- sync_n  out  1  SYNC~ to transmitter, active-low.
- d_out  out  32  d_in delayed 1 cycle; feeds descrambler s_d_in.
- d_valid  out  1  d_out carries a DATA-phase word.
- desc_reset_b  out  1  descrambler reset, active-low.
- desc_valid  out  1  d_valid delayed 1 cycle; aligned to descrambler output.
- link_up  out  1  high while in DATA.
- state_o  out  2  0=CGS, 1=ILAS_WAIT, 2=ILAS, 3=DATA.

Behaviour:
- Reset values: state CGS, sync_n=0, d_out=0, d_valid=0, desc_valid=0, desc_reset_b=0, link_up=0, all counters 0.
- Word predicates:
  - KW: k_in=4'hF and all bytes 8'hBC.
  - Error word: any dec_err bit set.
- CGS: sync_n=0.
  - kcnt increments on KW and clears on any non-KW word.
  - When kcnt reaches CGS_WORDS-1 and the current word is KW, go to ILAS_WAIT. sync_n=1 from the next cycle.
- ILAS_WAIT: sync_n=1.
  - A KW word holds the state.
  - Word with k_in[0]=1, d_in[7:0]=8'h1C (/R/): go to ILAS. This word is ILAS word 0 (wcnt=0, mcnt=0).
  - Any other word, an error word, or ILAS_TMO cycles elapsed: go to CGS.
- ILAS: wcnt counts 0..MF_WORDS-1 and wraps; mcnt increments on wrap.
  - At wcnt=0, byte 0 must be /R/ (K, 8'h1C).
  - At wcnt=MF_WORDS-1, byte 3 must be /A/ (k_in[3]=1, 8'h7C).
  - Other K bytes are ignored.
  - A failed check or an error word goes to CGS.
  - After wcnt=MF_WORDS-1 with mcnt=ILAS_MF-1, go to DATA.
- DATA entry: desc_reset_b rises on the cycle the state becomes DATA, one cycle before the first d_valid=1.
- DATA:
  - d_valid=1 for every word, 1 cycle after d_in.
  - desc_valid follows d_valid by one cycle.
  - link_up=1.
  - Error word: K byte other than 8'h7C/8'hFC, or any dec_err bit set. ecnt increments per error word, saturates at ERR_THR, and never wraps.
  - ecnt reaching ERR_THR goes to CGS.
  - CGS_WORDS consecutive KW words (transmitter re-init) go to CGS.
- Any transition to CGS, same cycle:
  - sync_n=0, desc_reset_b=0, d_valid=0, link_up=0.
  - desc_valid drops one cycle later.
  - kcnt, wcnt, mcnt, ecnt, timer cleared.
- Simultaneous events:
  - relink has priority over every transition.
  - A relink in CGS is ignored except for clearing kcnt.
- reset mid-operation: immediate return to reset values at the next edge.
- d_out is always d_in delayed 1 cycle, regardless of state.

Optional Feature:
- Macro: JESD_ILAS_CFG_CAPTURE_EN.
- With the macro:
  - Adds output ilas_cfg[111:0].
  - In ILAS multiframe mcnt=1, the 14 octets following /R/ and /Q/ (K, 8'h9C at byte 1 of word 0) are captured, octet n into ilas_cfg[8n+7:8n].
  - Capture is held until the next entry to CGS; reset value 0.
  - A missing /Q/ at byte 1 of that word goes to CGS.
- Without the macro: no port, no /Q/ check.

Test Plan:
- F=2, K=32 (MF_WORDS=16): 4 KW words, then 4×16 correct ILAS words, then data → sync_n rises after the 4th KW word; desc_reset_b rises after ILAS word 63; d_valid=1 one cycle later; state_o=3.
- 3 KW words, 1 word 32'h00BC_BCBC with k_in=4'hF, then 4 KW words → lock only after the final 4 KW words; sync_n stays 0 until then.
- ILAS multiframe 2, last word has byte 3 = 8'h7D → state_o returns to 0 and sync_n=0 the next cycle.
- DATA phase, 8 words with dec_err=4'h1 interleaved with clean words → relink on the 8th error word; 7 errors → link stays up.
- ILAS_WAIT with only KW words for 1024 cycles → return to CGS; relink pulse in DATA → sync_n=0 and d_valid=0 the same cycle.
- Macro on: ILAS multiframe 1 octets 8'h01..8'h0E → ilas_cfg=112'h0E0D..0201 after link_up.

Source files
------------

// File: rtl/jesd204b_rx_link_ctrl.sv
// Single-lane JESD204B RX link controller: CGS lock, ILAS check, then DATA phase.
// Optional feature macro JESD_ILAS_CFG_CAPTURE_EN adds the ilas_cfg capture port.
module jesd204b_rx_link_ctrl #(
  parameter int F         = 2,
  parameter int K         = 32,
  parameter int ILAS_MF   = 4,
  parameter int CGS_WORDS = 4,
  parameter int ILAS_TMO  = 1024,
  parameter int ERR_THR   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   d_in,
  input  logic [3:0]    k_in,
  input  logic [3:0]    dec_err,
  input  logic          relink,
  output logic          sync_n,
  output logic [31:0]   d_out,
  output logic          d_valid,
  output logic          desc_reset_b,
  output logic          desc_valid,
  output logic          link_up,
`ifdef JESD_ILAS_CFG_CAPTURE_EN
  output logic [111:0]  ilas_cfg,
`endif
  output logic [1:0]    state_o
);

  localparam int MF_WORDS = F * K / 4;
  localparam int KCW = $clog2(CGS_WORDS + 1);
  localparam int WCW = $clog2(MF_WORDS + 1);
  localparam int MCW = $clog2(ILAS_MF + 1);
  localparam int ECW = $clog2(ERR_THR + 1);
  localparam int TCW = $clog2(ILAS_TMO + 1);
  localparam logic [KCW-1:0] K_LAST = KCW'(CGS_WORDS - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(MF_WORDS - 1);
  localparam logic [MCW-1:0] M_LAST = MCW'(ILAS_MF - 1);
  localparam logic [MCW-1:0] M_CFG  = MCW'(1);
  localparam logic [ECW-1:0] E_LAST = ECW'(ERR_THR - 1);
  localparam logic [ECW-1:0] E_THR  = ECW'(ERR_THR);
  localparam logic [TCW-1:0] T_LAST = TCW'(ILAS_TMO - 1);

  typedef enum logic [1:0] {
    ST_CGS       = 2'd0,
    ST_ILAS_WAIT = 2'd1,
    ST_ILAS      = 2'd2,
    ST_DATA      = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [KCW-1:0]   r_kcnt, w_kcnt_nxt;
  logic [WCW-1:0]   r_wcnt, w_wcnt_nxt;
  logic [MCW-1:0]   r_mcnt, w_mcnt_nxt;
  logic [ECW-1:0]   r_ecnt, w_ecnt_nxt;
  logic [TCW-1:0]   r_timer, w_timer_nxt;
  logic [31:0]      r_d_out;
  logic             r_d_valid, r_desc_valid;
  logic             w_to_cgs, w_bad_k, w_ilas_fail;

  logic w_kw, w_err, w_r0, w_a3, w_q1;
  assign w_kw  = (k_in == 4'hF) && (d_in == 32'hBCBC_BCBC);
  assign w_err = |dec_err;
  assign w_r0  = k_in[0] && (d_in[7:0]   == 8'h1C);
  assign w_a3  = k_in[3] && (d_in[31:24] == 8'h7C);
  assign w_q1  = k_in[1] && (d_in[15:8]  == 8'h9C);

  // In DATA only /A/ (7C) and /F/ (FC) are legal control characters.
  always_comb begin
    w_bad_k = 1'b0;
    for (int b = 0; b < 4; b++)
      if (k_in[b] && d_in[8*b +: 8] != 8'h7C && d_in[8*b +: 8] != 8'hFC) w_bad_k = 1'b1;
  end

  assign w_ilas_fail = w_err
                     || (r_wcnt == '0 && !w_r0)
`ifdef JESD_ILAS_CFG_CAPTURE_EN
                     || (r_wcnt == '0 && r_mcnt == M_CFG && !w_q1)
`endif
                     || (r_wcnt == W_LAST && !w_a3);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_kcnt_nxt  = r_kcnt;
    w_wcnt_nxt  = r_wcnt;
    w_mcnt_nxt  = r_mcnt;
    w_ecnt_nxt  = r_ecnt;
    w_timer_nxt = r_timer;
    w_to_cgs    = 1'b0;
    case (r_state)
      ST_CGS: begin
        if (!w_kw)                 w_kcnt_nxt = '0;
        else if (r_kcnt == K_LAST) begin
          w_state_nxt = ST_ILAS_WAIT;
          w_kcnt_nxt  = '0;
        end else                   w_kcnt_nxt = r_kcnt + 1'b1;
      end
      ST_ILAS_WAIT: begin
        if (w_err || r_timer == T_LAST) w_to_cgs = 1'b1;
        else if (w_kw)                  w_timer_nxt = r_timer + 1'b1;
        else if (w_r0) begin
          // The /R/ that ends the wait is ILAS word 0, so ILAS resumes at word 1.
          w_state_nxt = ST_ILAS;
          w_wcnt_nxt  = WCW'(1);
          w_mcnt_nxt  = '0;
          w_timer_nxt = '0;
        end else                        w_to_cgs = 1'b1;
      end
      ST_ILAS: begin
        if (w_ilas_fail)            w_to_cgs = 1'b1;
        else if (r_wcnt == W_LAST) begin
          w_wcnt_nxt = '0;
          if (r_mcnt == M_LAST) begin
            w_state_nxt = ST_DATA;
            w_mcnt_nxt  = '0;
          end else w_mcnt_nxt = r_mcnt + 1'b1;
        end else                    w_wcnt_nxt = r_wcnt + 1'b1;
      end
      ST_DATA: begin
        if (!w_kw)                 w_kcnt_nxt = '0;
        else if (r_kcnt == K_LAST) w_to_cgs   = 1'b1;
        else                       w_kcnt_nxt = r_kcnt + 1'b1;
        if (w_err || w_bad_k) begin
          if (r_ecnt != E_THR) w_ecnt_nxt = r_ecnt + 1'b1;
          if (r_ecnt >= E_LAST) w_to_cgs  = 1'b1;
        end
      end
      default: w_to_cgs = 1'b1;
    endcase
    if (relink) w_to_cgs = 1'b1;
    if (w_to_cgs) begin
      w_state_nxt = ST_CGS;
      w_kcnt_nxt  = '0;
      w_wcnt_nxt  = '0;
      w_mcnt_nxt  = '0;
      w_ecnt_nxt  = '0;
      w_timer_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_CGS;
      r_kcnt       <= '0;
      r_wcnt       <= '0;
      r_mcnt       <= '0;
      r_ecnt       <= '0;
      r_timer      <= '0;
      r_d_out      <= '0;
      r_d_valid    <= 1'b0;
      r_desc_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_kcnt       <= w_kcnt_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_mcnt       <= w_mcnt_nxt;
      r_ecnt       <= w_ecnt_nxt;
      r_timer      <= w_timer_nxt;
      r_d_out      <= d_in;
      r_d_valid    <= (r_state == ST_DATA) && (w_state_nxt == ST_DATA);
      r_desc_valid <= r_d_valid;
    end
  end

`ifdef JESD_ILAS_CFG_CAPTURE_EN
  logic [111:0] r_ilas_cfg;
  // Octets after /R/,/Q/ in multiframe 1: word 0 bytes 2..3, then words 1..3 whole.
  always_ff @(posedge clk) begin
    if (reset || w_to_cgs) r_ilas_cfg <= '0;
    else if (r_state == ST_ILAS && r_mcnt == M_CFG) begin
      case (r_wcnt)
        WCW'(0): r_ilas_cfg[15:0]   <= d_in[31:16];
        WCW'(1): r_ilas_cfg[47:16]  <= d_in;
        WCW'(2): r_ilas_cfg[79:48]  <= d_in;
        WCW'(3): r_ilas_cfg[111:80] <= d_in;
        default: ;
      endcase
    end
  end
  assign ilas_cfg = r_ilas_cfg;
`endif

  assign sync_n       = (r_state != ST_CGS);
  assign desc_reset_b = (r_state == ST_DATA);
  assign link_up      = (r_state == ST_DATA);
  assign state_o      = r_state;
  assign d_out        = r_d_out;
  assign d_valid      = r_d_valid;
  assign desc_valid   = r_desc_valid;

endmodule
